// File: rtl/bcd_display_scanner.sv
// ---------------------------------------------------------------------------
// bcd_display_scanner
//
// Time-multiplexed seven-segment driver for a common-anode display. A packed
// vector of BCD digits is captured into a pending register and copied to the
// displayed (active) register only at a frame boundary, so a frame never
// mixes old and new data. Each digit slot lasts CLK_DIV cycles. The first
// GUARD cycles of a slot are blanked to avoid ghosting. A registered error
// flag reports any active digit above 9.
//
// Optional feature (macro BCD_SCAN_LEADING_ZERO_BLANK_EN):
//   defined   - digit k (k >= 1) is blanked during its slot when it and every
//               higher active digit are zero; digit 0 is always shown.
//   undefined - every digit is always displayed.
//
// Parameters:
//   NUM_DIGITS  number of BCD digits scanned (>= 1)
//   CLK_DIV     clock cycles per digit slot (>= 2)
//   GUARD       blank cycles at the start of each slot (0 <= GUARD < CLK_DIV)
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   digit_in    packed BCD digits, digit k at [4k+3:4k], digit 0 is the LSD
//   load        captures digit_in into the pending register
//   seg         segments a..g on bits 0..6, active-high (registered)
//   an          digit enables, active-low, at most one low (registered)
//   frame_done  one-cycle pulse for the last cycle of the final slot
//   err         high while any active digit is greater than 9
// ---------------------------------------------------------------------------
module bcd_display_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 1000,
  parameter int GUARD      = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digit_in,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done,
  output logic                    err
);

  localparam int PC_W  = $clog2(CLK_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [PC_W-1:0]         pc;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] pending;
  logic [4*NUM_DIGITS-1:0] active;

  logic       pc_wrap;
  logic       frame_end;
  logic       in_guard;
  logic       blank;
  logic       any_bad;
  logic [3:0] cur_digit;

  // Segment patterns a..g on bits 0..6; non-BCD codes show a dash.
  function automatic logic [6:0] decode(input logic [3:0] d);
    unique case (d)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h40;
    endcase
  endfunction

  assign pc_wrap   = (pc == PC_LAST);
  assign frame_end = pc_wrap && (idx == IDX_LAST);

  // With no guard cycles the comparison would be constant-false.
  generate
    if (GUARD == 0) begin : g_no_guard
      assign in_guard = 1'b0;
    end else begin : g_guard
      assign in_guard = (pc < PC_W'(GUARD));
    end
  endgenerate

`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
  logic zero_run;
`endif

  always_comb begin
    // NOTE: every variable gets a default before any conditional write so
    // no path leaves it unassigned, which would otherwise infer a latch.
    cur_digit = 4'd0;
    any_bad   = 1'b0;
    blank     = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IDX_W'(k)) cur_digit = active[4*k +: 4];
      if (active[4*k +: 4] > 4'd9) any_bad = 1'b1;
    end
`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
    // Walk down from the most significant digit; zero_run stays set only
    // while this digit and all above it are zero. Digit 0 is never visited.
    zero_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_run = zero_run && (active[4*k +: 4] == 4'd0);
      if ((idx == IDX_W'(k)) && zero_run) blank = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    if (rst) begin
      // NOTE: pending/active are plain flop registers, not a RAM, so they are
      // reset with everything else and the display starts from known zeros.
      pc         <= '0;
      idx        <= '0;
      pending    <= '0;
      active     <= '0;
      seg        <= '0;
      an         <= '1;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      pc <= pc_wrap ? '0 : pc + 1'b1;
      if (pc_wrap) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;

      if (load) pending <= digit_in;
      // A load coinciding with the boundary bypasses pending so the newest
      // data is shown in the frame that starts on this edge.
      if (frame_end) active <= load ? digit_in : pending;

      frame_done <= frame_end;
      err        <= any_bad;

      if (in_guard || blank) begin
        an  <= '1;
        seg <= '0;
      end else begin
        an  <= ~(NUM_DIGITS'(1) << idx);
        seg <= decode(cur_digit);
      end
    end
  end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// ---------------------------------------------------------------------------
// tb_bcd_display_scanner
//
// Bench for bcd_display_scanner with NUM_DIGITS=4, CLK_DIV=8, GUARD=2.
// A cycle model predicts the registered outputs for each edge; predictions
// are queued when the inputs are driven and popped once the edge has passed.
// Directed checks against fixed constants cover reset latency, scan order,
// tear-free update, invalid digits, boundary collision, mid-slot reset and
// leading-zero behaviour (BCD_SCAN_LEADING_ZERO_BLANK_EN aware).
// ---------------------------------------------------------------------------
module tb_bcd_display_scanner;

  localparam int N   = 4;
  localparam int DIV = 8;
  localparam int GRD = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] digit_in;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_done;
  logic        err;

  bcd_display_scanner #(
    .NUM_DIGITS(N),
    .CLK_DIV   (DIV),
    .GUARD     (GRD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .digit_in  (digit_in),
    .load      (load),
    .seg       (seg),
    .an        (an),
    .frame_done(frame_done),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] an;
    logic       fd;
    logic       err;
  } out_t;

  out_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Model state: values the DUT holds after the most recent edge.
  int          m_pc;
  int          m_idx;
  logic [15:0] m_pend;
  logic [15:0] m_act;

  logic [3:0] t2_an  [4];
  logic [6:0] t2_seg [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  function automatic logic lz_blank();
`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
    if (m_idx == 0) return 1'b0;
    for (int k = m_idx; k < N; k++)
      if (m_act[4*k +: 4] != 4'd0) return 1'b0;
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // One clock: predict the outputs of the coming edge, advance the model,
  // let the edge pass, then compare against the queued prediction.
  task automatic step();
    out_t e;
    logic wrap;
    logic bnd;
    if (rst) begin
      e.seg = 7'h00; e.an = 4'hF; e.fd = 1'b0; e.err = 1'b0;
    end else begin
      e.fd  = (m_pc == DIV - 1) && (m_idx == N - 1);
      e.err = 1'b0;
      for (int k = 0; k < N; k++)
        if (m_act[4*k +: 4] > 4'd9) e.err = 1'b1;
      if (m_pc < GRD || lz_blank()) begin
        e.an = 4'hF; e.seg = 7'h00;
      end else begin
        e.an  = ~(4'b0001 << m_idx);
        e.seg = seg_of(m_act[4*m_idx +: 4]);
      end
    end
    exp_q.push_back(e);

    if (rst) begin
      m_pc = 0; m_idx = 0; m_pend = '0; m_act = '0;
    end else begin
      wrap = (m_pc == DIV - 1);
      bnd  = wrap && (m_idx == N - 1);
      if (bnd) m_act = load ? digit_in : m_pend;
      if (load) m_pend = digit_in;
      m_pc = wrap ? 0 : m_pc + 1;
      if (wrap) m_idx = (m_idx == N - 1) ? 0 : m_idx + 1;
    end

    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("seg", 32'(seg), 32'(e.seg));
    check("an", 32'(an), 32'(e.an));
    check("frame_done", 32'(frame_done), 32'(e.fd));
    check("err", 32'(err), 32'(e.err));
  endtask

  // Step until the DUT's internal slot/prescaler equals (s, p); bounded.
  task automatic to_slot(input int s, input int p);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(m_idx == s && m_pc == p) && n < 200);
    if (n >= 200) check("to_slot timeout", 32'(n), 32'(0));
  endtask

  task automatic load_once(input logic [15:0] d);
    load     = 1'b1;
    digit_in = d;
    step();
    load     = 1'b0;
  endtask

  initial begin
    t2_an  = '{4'hE, 4'hD, 4'hB, 4'h7};
    t2_seg = '{7'h66, 7'h4F, 7'h5B, 7'h06};
    m_pc = 0; m_idx = 0; m_pend = '0; m_act = '0;
    rst = 1'b1; load = 1'b0; digit_in = '0;

    // 1. Reset and first-output latency.
    repeat (3) begin
      step();
      check("t1 rst an", 32'(an), 32'hF);
      check("t1 rst seg", 32'(seg), 32'h0);
    end
    rst = 1'b0;
    step(); check("t1 lat1 an", 32'(an), 32'hF);
    step(); check("t1 lat2 an", 32'(an), 32'hF);
    step(); check("t1 lat3 an", 32'(an), 32'hE);
    check("t1 lat3 seg", 32'(seg), 32'h3F);

    // 2. Load 1234 and scan a full frame.
    load_once(16'h1234);
    to_slot(0, 0);
    for (int s = 0; s < N; s++) begin
      for (int p = 0; p < DIV; p++) begin
        step();
        if (p < GRD) begin
          check("t2 guard an", 32'(an), 32'hF);
        end else begin
          check("t2 an", 32'(an), 32'(t2_an[s]));
          check("t2 seg", 32'(seg), 32'(t2_seg[s]));
        end
        check("t2 frame_done", 32'(frame_done), 32'(s == N - 1 && p == DIV - 1));
      end
    end

    // 3. Load during slot 1: rest of the frame keeps 1234.
    to_slot(1, 3);
    load_once(16'h5678);
    to_slot(2, 4); step();
    check("t3 old d2 seg", 32'(seg), 32'h5B);
    to_slot(3, 4); step();
    check("t3 old d3 seg", 32'(seg), 32'h06);
    to_slot(0, 4); step();
    check("t3 new d0 an", 32'(an), 32'hE);
    check("t3 new d0 seg", 32'(seg), 32'h7F);

    // 4. Invalid digit and error flag timing.
    load_once(16'h9A09);
    to_slot(0, 0);
    check("t4 err before", 32'(err), 32'h0);
    step();
    check("t4 err after", 32'(err), 32'h1);
    to_slot(2, 4); step();
    check("t4 dash an", 32'(an), 32'hB);
    check("t4 dash seg", 32'(seg), 32'h40);
    load_once(16'h0009);
    to_slot(0, 0);
    check("t4 err held", 32'(err), 32'h1);
    step();
    check("t4 err clear", 32'(err), 32'h0);

    // 5. Load on the boundary edge, then mid-slot reset.
    to_slot(3, 7);
    load_once(16'h0042);
    step(); step(); step();
    check("t5 collide an", 32'(an), 32'hE);
    check("t5 collide seg", 32'(seg), 32'h5B);
    to_slot(2, 4);
    rst = 1'b1;
    step();
    check("t5 rst an", 32'(an), 32'hF);
    check("t5 rst seg", 32'(seg), 32'h0);
    rst = 1'b0;
    step(); check("t5 restart g0", 32'(an), 32'hF);
    step(); check("t5 restart g1", 32'(an), 32'hF);
    step();
    check("t5 restart an", 32'(an), 32'hE);
    check("t5 restart seg", 32'(seg), 32'h3F);

    // 6. Leading zeros.
    load_once(16'h0042);
    to_slot(0, 0);
    to_slot(1, 4); step();
    check("t6 d1 an", 32'(an), 32'hD);
    check("t6 d1 seg", 32'(seg), 32'h66);
    to_slot(3, 4); step();
`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
    check("t6 d3 an", 32'(an), 32'hF);
    check("t6 d3 seg", 32'(seg), 32'h00);
`else
    check("t6 d3 an", 32'(an), 32'h7);
    check("t6 d3 seg", 32'(seg), 32'h3F);
`endif
    load_once(16'h0000);
    to_slot(0, 0);
    to_slot(0, 4); step();
    check("t6 zero d0 an", 32'(an), 32'hE);
    check("t6 zero d0 seg", 32'(seg), 32'h3F);
    to_slot(1, 4); step();
`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
    check("t6 zero d1 an", 32'(an), 32'hF);
`else
    check("t6 zero d1 an", 32'(an), 32'hD);
`endif

    // Random loads, including back-to-back and non-BCD codes.
    for (int i = 0; i < 300; i++) begin
      load     = ($urandom_range(0, 7) == 0);
      digit_in = 16'($urandom());
      step();
    end
    load = 1'b0;
    repeat (2 * N * DIV) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
